// File: rtl/i2c_master_seq.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Open-drain style outputs: *_oe = 1 pulls the line low, 0 releases it.
module i2c_master_seq #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic       req_rw,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       busy,
  output logic [3:0] state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so requests are ignored while busy.
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP, S_DONE
  } state_t;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t         state, nxt_state;
  logic [DW-1:0]  div_cnt, nxt_div;
  logic [1:0]     phase, nxt_phase;
  logic [2:0]     bit_cnt, nxt_bit;
  logic [6:0]     addr_q;
  logic           rw_q;
  logic [7:0]     wdata_q;
  logic [7:0]     rdata_sh;
  logic           nack_q;
  logic           samp_now;
  logic           addr_nack;
  logic           nxt_scl, nxt_sda;
  logic [7:0]     tx_byte;

  assign state_dbg = state;
  assign samp_now  = (div_cnt == '0) && (phase == 2'd3);
  // With DIV=1 the ack sample and the slot end share a cycle, so fold in sda_in.
  assign addr_nack = nack_q | (samp_now & sda_in);

  always_comb begin
    nxt_state = state;
    nxt_div   = div_cnt;
    nxt_phase = phase;
    nxt_bit   = bit_cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          nxt_state = S_START;
          nxt_div   = '0;
          nxt_phase = 2'd0;
          nxt_bit   = 3'd0;
        end
      end
      S_DONE: nxt_state = S_IDLE;
      default: begin
        if (div_cnt == DIV_LAST) begin
          nxt_div   = '0;
          nxt_phase = phase + 2'd1;
          if (phase == 2'd3) begin
            nxt_bit = 3'd0;
            case (state)
              S_START: nxt_state = S_ADDR;
              S_ADDR:  if (bit_cnt == 3'd7) nxt_state = S_AACK; else nxt_bit = bit_cnt + 3'd1;
              S_AACK:  nxt_state = addr_nack ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
              S_WDATA: if (bit_cnt == 3'd7) nxt_state = S_WACK; else nxt_bit = bit_cnt + 3'd1;
              S_RDATA: if (bit_cnt == 3'd7) nxt_state = S_RACK; else nxt_bit = bit_cnt + 3'd1;
              S_WACK:  nxt_state = S_STOP;
              S_RACK:  nxt_state = S_STOP;
              S_STOP:  nxt_state = S_DONE;
              default: nxt_state = S_IDLE;
            endcase
          end
        end else begin
          nxt_div = div_cnt + DW'(1);
        end
      end
    endcase
  end

  // Line levels for the position the sequencer is about to enter.
  always_comb begin
    nxt_scl = 1'b0;
    nxt_sda = 1'b0;
    tx_byte = (nxt_state == S_ADDR) ? {addr_q, rw_q} : wdata_q;
    case (nxt_state)
      S_START: nxt_sda = nxt_phase[1];
      S_ADDR, S_WDATA: begin
        nxt_scl = ~nxt_phase[1];
        nxt_sda = ~tx_byte[3'd7 - nxt_bit];
      end
      S_AACK, S_WACK, S_RDATA, S_RACK: nxt_scl = ~nxt_phase[1];
      S_STOP: begin
        nxt_scl = (nxt_phase == 2'd0);
        nxt_sda = (nxt_phase != 2'd3);
      end
      default: begin
        nxt_scl = 1'b0;
        nxt_sda = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      addr_q    <= 7'd0;
      rw_q      <= 1'b0;
      wdata_q   <= 8'd0;
      rdata_sh  <= 8'd0;
      nack_q    <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
    end else begin
      state     <= nxt_state;
      div_cnt   <= nxt_div;
      phase     <= nxt_phase;
      bit_cnt   <= nxt_bit;
      scl_oe    <= nxt_scl;
      sda_oe    <= nxt_sda;
      req_ready <= (nxt_state == S_IDLE);
      busy      <= (nxt_state != S_IDLE);
      rsp_valid <= (nxt_state == S_DONE);
      if (state == S_IDLE && req_valid) begin
        addr_q   <= req_addr;
        rw_q     <= req_rw;
        wdata_q  <= req_wdata;
        nack_q   <= 1'b0;
        rdata_sh <= 8'h00;
      end
      if (samp_now) begin
        case (state)
          S_AACK, S_WACK: if (sda_in) nack_q <= 1'b1;
          S_RDATA:        rdata_sh <= {rdata_sh[6:0], sda_in};
          default:        ;
        endcase
      end
      if (nxt_state == S_DONE) begin
        rsp_rdata <= (rw_q && !nack_q) ? rdata_sh : 8'h00;
        rsp_nack  <= nack_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: slot-level bus model, per-cycle compare, response scoreboard.
module tb_i2c_master_seq;

  localparam int DIV  = 2;
  localparam int SLOT = 4 * DIV;

  logic       clk, rst;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic       rsp_valid, rsp_nack, scl_oe, sda_oe, sda_in, busy;
  logic [3:0] state_dbg;
  logic       slave_pull;

  // Wired-AND bus: low if either the master or the slave pulls it.
  assign sda_in = !(sda_oe || slave_pull);

  i2c_master_seq #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_acc   = 0;
  int rises   = 0;
  logic [31:0] bits = '0;
  logic        prev_scl = 1'b0;

  // slave behaviour for the next accepted request
  logic       cfg_ack_a, cfg_ack_d;
  logic [7:0] cfg_rbyte;

  // transaction-level model
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t    m_st = M_IDLE;
  int         m_k, m_len;
  logic [6:0] m_addr;
  logic       m_rw, m_ack_a, m_ack_d;
  logic [7:0] m_wdata, m_rbyte, m_rdata;
  logic       m_nack;
  logic [8:0] m_exp_rsp;
  logic [8:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = M_IDLE; m_k = 0; m_len = 0; m_rdata = 8'h00; m_nack = 1'b0;
      exp_q.delete();
    end else begin
      case (m_st)
        M_IDLE: if (req_valid) begin
          m_addr = req_addr; m_rw = req_rw; m_wdata = req_wdata;
          m_ack_a = cfg_ack_a; m_ack_d = cfg_ack_d; m_rbyte = cfg_rbyte;
          // 20 slots normally, 11 when the address is not acknowledged
          m_len = m_ack_a ? 20 * SLOT : 11 * SLOT;
          m_exp_rsp = {(m_rw && m_ack_a) ? m_rbyte : 8'h00,
                       !m_ack_a || (!m_rw && !m_ack_d)};
          exp_q.push_back(m_exp_rsp);
          m_k = 0; m_st = M_RUN;
          t_acc = cyc; rises = 0; bits = '0;
        end
        M_RUN: if (m_k == m_len - 1) begin
          m_st = M_DONE;
          {m_rdata, m_nack} = m_exp_rsp;
        end else begin
          m_k++;
        end
        default: m_st = M_IDLE;
      endcase
      cyc++;
    end
  end

  // {scl_oe, sda_oe} the bus must show at cycle k of a transaction
  function automatic logic [1:0] lvl(int k);
    int slot = k / SLOT;
    int ph   = (k % SLOT) / DIV;
    int last = m_len / SLOT - 1;
    logic [7:0] ab = {m_addr, m_rw};
    logic sda = 1'b0;
    if (slot == 0) return {1'b0, 1'(ph >= 2)};
    if (slot == last) return {1'(ph == 0), 1'(ph != 3)};
    if (slot <= 8) sda = !ab[8 - slot];
    else if (slot >= 10 && slot <= 17 && !m_rw) sda = !m_wdata[17 - slot];
    return {1'(ph < 2), sda};
  endfunction

  function automatic logic slave_fn(int k);
    int slot = k / SLOT;
    if (slot == 9) return m_ack_a;
    if (m_ack_a && !m_rw && slot == 18) return m_ack_d;
    if (m_ack_a && m_rw && slot >= 10 && slot <= 17) return !m_rbyte[17 - slot];
    return 1'b0;
  endfunction

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [12:0] exp_v, act_v;
    logic [8:0]  e;
    case (m_st)
      M_IDLE:  exp_v = {1'b1, 1'b0, 2'b00, 1'b0, m_rdata, m_nack};
      M_RUN:   exp_v = {1'b0, 1'b1, lvl(m_k), 1'b0, m_rdata, m_nack};
      default: exp_v = {1'b0, 1'b1, 2'b00, 1'b1, m_rdata, m_nack};
    endcase
    act_v = {req_ready, busy, scl_oe, sda_oe, rsp_valid, rsp_rdata, rsp_nack};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_check cyc=%0d k=%0d got={rdy,busy,scl,sda,rv,rd,nk}=%h want=%h",
               cyc, m_k, act_v, exp_v);
    end
    if (rsp_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected cyc=%0d got rdata=%h nack=%b want no response",
                 cyc, rsp_rdata, rsp_nack);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_rdata, rsp_nack} !== e) begin
          n_fail++;
          $display("FAIL rsp_scoreboard got rdata=%h nack=%b want rdata=%h nack=%b",
                   rsp_rdata, rsp_nack, e[8:1], e[0]);
        end
      end
    end
    if (prev_scl && !scl_oe) begin
      bits = {bits[30:0], sda_in};
      rises++;
    end
    prev_scl   = scl_oe;
    slave_pull = (m_st == M_RUN) ? slave_fn(m_k) : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                      input logic aa, input logic ad, input logic [7:0] rb);
    @(negedge clk);
    cfg_ack_a = aa; cfg_ack_d = ad; cfg_rbyte = rb;
    req_addr = a; req_rw = rw; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 7'($urandom_range(0, 127));
    req_wdata = 8'($urandom_range(0, 255));
    req_rw    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rsp(input int max_cyc, output int lat);
    int n = 0;
    lat = -1;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) begin
        lat = cyc - t_acc;
        break;
      end
    end
    #1;
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_timeout got no rsp_valid within %0d cycles", max_cyc);
    end
  endtask

  initial begin
    int lat, d, n;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0; req_wdata = '0;
    slave_pull = 1'b0; cfg_ack_a = 1'b1; cfg_ack_d = 1'b1; cfg_rbyte = 8'h00;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {req_ready, busy, scl_oe, sda_oe, rsp_valid, rsp_rdata, rsp_nack},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    @(negedge clk);
    rst = 1'b1;

    // write 0x50 / 0xA5, slave ACKs both
    send(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    wait_rsp(400, lat);
    chk("t1_latency", lat, 161);
    chk("t1_rsp", {rsp_rdata, rsp_nack}, {8'h00, 1'b0});
    chk("t1_rises", rises, 19);
    chk("t1_bus_bits", bits[18:0], {7'h50, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0});

    // read 0x3C, slave returns 0x96
    send(7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h96);
    wait_rsp(400, lat);
    chk("t2_latency", lat, 161);
    chk("t2_rsp", {rsp_rdata, rsp_nack}, {8'h96, 1'b0});
    chk("t2_bus_bits", bits[18:0], {7'h3C, 1'b1, 1'b0, 8'h96, 1'b1, 1'b0});

    // read with no slave: address NACK, short transaction
    send(7'h3C, 1'b1, 8'h00, 1'b0, 1'b1, 8'h96);
    wait_rsp(400, lat);
    chk("t3_latency", lat, 89);
    chk("t3_rsp", {rsp_rdata, rsp_nack}, {8'h00, 1'b1});
    chk("t3_rises", rises, 10);

    // write with data NACK
    send(7'h11, 1'b0, 8'h3E, 1'b1, 1'b0, 8'h00);
    wait_rsp(400, lat);
    chk("t4_latency", lat, 161);
    chk("t4_rsp", {rsp_rdata, rsp_nack}, {8'h00, 1'b1});

    // reset during WDATA bit 4 (slot 14, phase 0)
    send(7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00);
    n = 0;
    while (!(m_st == M_RUN && m_k == 14 * SLOT + 1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("t5_lines_before_reset", {scl_oe, sda_oe}, 2'b11);
    rst = 1'b0;
    #1;
    chk("t5_lines_async_release", {scl_oe, sda_oe, busy, rsp_valid}, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send(7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00);
    wait_rsp(400, lat);
    chk("t5_fresh_latency", lat, 161);
    chk("t5_fresh_rsp", {rsp_rdata, rsp_nack}, {8'h00, 1'b0});

    // req_valid held, inputs changed mid-transaction
    @(negedge clk);
    cfg_ack_a = 1'b1; cfg_ack_d = 1'b1; cfg_rbyte = 8'h00;
    req_addr = 7'h21; req_rw = 1'b0; req_wdata = 8'h5A; req_valid = 1'b1;
    repeat (20) @(negedge clk);
    req_addr = 7'h7F; req_wdata = 8'hFF;
    wait_rsp(400, lat);
    d = cyc;
    chk("t6_first_latency", lat, 161);
    chk("t6_first_bus_bits", bits[18:0], {7'h21, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("t6_second_accept_cycle", t_acc, d + 1);
    wait_rsp(400, lat);
    chk("t6_second_latency", lat, 161);
    chk("t6_second_bus_bits", bits[18:0], {7'h7F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0});

    repeat (4) @(negedge clk);
    #1;
    chk("leftover_responses", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no end of test want finish before 500000 ns");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_master_seq.md
I2C_MASTER_SEQ -- requirements
Module: i2c_master_seq

Interface
REQ-001 Parameter: DIV, default 4, clk cycles per SCL quarter-bit phase; legal range >= 1.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  requester has a transaction pending.
REQ-005 req_ready  out  1  block accepts a request; transfer occurs when req_valid && req_ready.
REQ-006 req_addr  in  7  7-bit target address, sent MSB first.
REQ-007 req_rw  in  1  0 = single-byte write, 1 = single-byte read.
REQ-008 req_wdata  in  8  write byte, sent MSB first.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  8  read byte; 0x00 for writes and aborted reads.
REQ-011 rsp_nack  out  1  1 = address or write-data NACK seen; valid with rsp_valid.
REQ-012 scl_oe  out  1  1 = pull SCL low; 0 = release (high via pull-up).
REQ-013 sda_oe  out  1  1 = pull SDA low; 0 = release.
REQ-014 sda_in  in  1  sampled bus SDA level, already synchronised.
REQ-015 busy  out  1  high from acceptance through rsp_valid cycle inclusive.

Function
REQ-016 The block SHALL run the FSM IDLE -> START -> ADDR -> AACK -> (WDATA -> WACK | RDATA -> RACK) -> STOP -> DONE -> IDLE.
REQ-017 The block SHALL assert req_ready only in IDLE and capture req_addr/req_rw/req_wdata on acceptance; later input changes are ignored.
REQ-018 Every bit slot SHALL last 4 phases of DIV cycles (4*DIV cycles); a phase counter and a bit counter (0-7) SHALL sequence it.
REQ-019 Data/ack slots: SCL low in phases 0-1, high in phases 2-3; sda_oe updates only on first cycle of phase 0; sda_in sampled on first cycle of phase 3.
REQ-020 START (1 slot, begins cycle after acceptance): SCL high all phases; SDA released phases 0-1, pulled low phases 2-3.
REQ-021 ADDR: 8 slots, address bits 6..0 then captured rw bit.
REQ-022 AACK/WACK: SDA released; sampled 0 = ACK, 1 = NACK.
REQ-023 Address NACK SHALL skip the data phase, go to STOP, set rsp_nack=1, rsp_rdata=0x00.
REQ-024 WDATA: 8 slots of write byte; WACK NACK sets rsp_nack=1; STOP follows either way.
REQ-025 RDATA: SDA released for 8 slots, sampled bits shifted in MSB first; RACK SHALL keep SDA released (master NACK, single-byte read).
REQ-026 STOP (1 slot): phase 0 SCL low, SDA low; phases 1-2 SCL high, SDA low; phase 3 SCL high, SDA released.
REQ-027 DONE SHALL last exactly one cycle, asserting rsp_valid with rsp_rdata/rsp_nack; they hold until next DONE.
REQ-028 Latency, acceptance at cycle t: full transaction (20 slots) rsp_valid at t+80*DIV+1; address NACK (11 slots) at t+44*DIV+1.
REQ-029 No clock stretching or arbitration-loss detection; sda_in is not checked outside ack/read sampling.
REQ-030 req_valid during busy SHALL have no effect; earliest next acceptance is the cycle after DONE.

Reset
REQ-031 While rst=0: state IDLE, scl_oe=0, sda_oe=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00, rsp_nack=0, counters 0.
REQ-032 Reset mid-transaction SHALL release both lines asynchronously, generate no STOP and no rsp_valid.
REQ-033 First acceptance is possible on the first rising clk edge after rst deasserts.

Verification (DIV=2)
REQ-034 Write addr 0x50 data 0xA5, slave ACKs -> SDA bits 1010000,0,ack,10100101,ack between START/STOP; rsp_valid at t+161, rsp_nack=0, rsp_rdata=0x00.
REQ-035 Read addr 0x3C, slave ACKs and drives 0x96 -> sda_oe=0 through RDATA/RACK; rsp_rdata=0x96, rsp_nack=0 at t+161.
REQ-036 No slave (SDA high at AACK) -> STOP immediately after AACK slot; rsp_valid at t+89, rsp_nack=1, rsp_rdata=0x00.
REQ-037 Write with data NACK -> full 20 slots; rsp_nack=1 at t+161.
REQ-038 rst low during WDATA bit 4 -> scl_oe=sda_oe=0 without clk edge, no rsp_valid; after release a fresh write completes normally.
REQ-039 req_valid held high, req_addr changed mid-transaction -> req_ready=0 throughout; old address on bus; second request accepted cycle after DONE.
